// File: rtl/if_stage.sv
// Instruction-fetch stage: pipelined imem read port, credit-tracked prefetch FIFO, redirect flush.
// Optional IF_BYPASS_EN: forward a returning word straight to the outputs when the FIFO is empty.
module if_stage #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [15:0]       i_imem_rdata,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_ir_valid,
    output logic [15:0]       o_ir_cache,
    output logic [ADDR_W-1:0] o_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    cnt_t              count_q, count_d, outst_q, outst_d, discard_q, discard_d;
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic [15:0]       ir_mem [DEPTH];

    logic [CW:0] inflight;
    logic        grant, rsp, drop, keep, head_valid, push, pop;

    // Credit covers both buffered words and reads still in flight, so a push never overflows.
    assign inflight    = {1'b0, count_q} + {1'b0, outst_q};
    assign o_imem_req  = !rst && (inflight < DEPTH_C);
    assign o_imem_addr = fetch_pc_q;

    assign grant      = o_imem_req && i_imem_gnt;
    assign rsp        = i_imem_rvalid && (outst_q != '0);
    assign drop       = rsp && (discard_q != '0);
    assign keep       = rsp && (discard_q == '0) && !i_redirect;
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && !i_stall;

`ifdef IF_BYPASS_EN
    logic bypass;
    assign bypass     = keep && (count_q == '0) && !rst;
    assign o_ir_valid = head_valid || bypass;
    assign o_ir_cache = bypass ? i_imem_rdata : ir_mem[rd_ptr_q];
    assign o_pc       = bypass ? resp_pc_q : pc_mem[rd_ptr_q];
    assign push       = keep && !(bypass && !i_stall);
`else
    assign o_ir_valid = head_valid;
    assign o_ir_cache = ir_mem[rd_ptr_q];
    assign o_pc       = pc_mem[rd_ptr_q];
    assign push       = keep;
`endif

    always_comb begin
        fetch_pc_d = grant ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
        resp_pc_d  = keep ? resp_pc_q + ADDR_W'(1) : resp_pc_q;
        outst_d    = outst_q + cnt_t'(grant) - cnt_t'(rsp);
        discard_d  = drop ? discard_q - cnt_t'(1) : discard_q;
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (i_redirect) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_d = i_redirect_pc;
            resp_pc_d  = i_redirect_pc;
            discard_d  = outst_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= resp_pc_q;
            ir_mem[wr_ptr_q] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model plus an expected-output scoreboard.
module tb_if_stage;

`ifdef IF_BYPASS_EN
    localparam int LAT_MIN = 1;
`else
    localparam int LAT_MIN = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [15:0] rdata = 16'h0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [15:0] i_redirect_pc = 16'h0;
    logic        o_ir_valid;
    logic [15:0] o_ir_cache;
    logic [15:0] o_pc;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_ir_valid   (o_ir_valid),
        .o_ir_cache   (o_ir_cache),
        .o_pc         (o_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] addr; int due;} pend_t;
    typedef struct {logic [15:0] pc; logic [15:0] ir;} exp_t;
    typedef struct {
        logic [15:0] rpc;
        int          lat;
        int          need_pend;
        bit          need_rv;
        bit          gnt_in_redir;
        logic [15:0] exp0, exp1, exp2;
    } vec_t;

    pend_t pend[$];
    exp_t  expq[$];

    logic        stall = 1'b0, redir = 1'b0, gnt_en = 1'b1;
    logic [15:0] redir_pc = 16'h0;
    int          lat = 1;
    int          cyc = 0, n_chk = 0, n_fail = 0, n_grants = 0;
    int          fg_cyc = -1, fv_cyc = -1, n_cap = 0;
    logic [15:0] cap [3];
    logic        s_valid, s_req;
    logic [15:0] s_ir, s_pc, s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic mark();
        fg_cyc = -1;
        fv_cyc = -1;
        n_cap  = 0;
        for (int i = 0; i < 3; i++) cap[i] = 16'hxxxx;
    endtask

    // One clock cycle: drive memory/control inputs, sample outputs, score consumes, advance models.
    task automatic step();
        logic        g;
        logic [15:0] ga;
        exp_t        e;
        rst = rst;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = 16'h1000 + pend[0].addr;
        end else begin
            rvalid = 1'b0;
            rdata  = 16'hdead;
        end
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = redir_pc;
        #1;
        gnt = gnt_en && o_imem_req;
        #1;
        g       = o_imem_req && gnt;
        ga      = o_imem_addr;
        s_valid = o_ir_valid;
        s_req   = o_imem_req;
        s_ir    = o_ir_cache;
        s_pc    = o_pc;
        s_addr  = o_imem_addr;
        if (!rst) begin
            if (o_ir_valid && fv_cyc < 0) fv_cyc = cyc;
            if (g && fg_cyc < 0) fg_cyc = cyc;
            if (o_ir_valid && !stall) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_pop: got pc %h ir %h, expected no valid output", o_pc,
                             o_ir_cache);
                end else begin
                    e = expq.pop_front();
                    check("pop_pc_ir", {o_pc, o_ir_cache}, {e.pc, e.ir});
                    if (n_cap < 3) begin
                        cap[n_cap] = o_pc;
                        n_cap++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (rvalid) void'(pend.pop_front());
        if (redir) expq.delete();
        if (g) begin
            n_grants++;
            pend.push_back('{addr: ga, due: cyc + lat});
            if (!redir) expq.push_back('{pc: ga, ir: 16'h1000 + ga});
        end
        if (rst) begin
            pend.delete();
            expq.delete();
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("req_low_in_reset", 32'(s_req), 32'd0);
        rst = 1'b0;
    endtask

    vec_t vecs [3];

    initial begin
        vecs[0] = '{16'h0040, 3, 2, 1'b0, 1'b0, 16'h0040, 16'h0041, 16'h0042};
        vecs[1] = '{16'h0100, 1, 1, 1'b1, 1'b1, 16'h0100, 16'h0101, 16'h0102};
        vecs[2] = '{16'hFFFE, 2, 1, 1'b0, 1'b1, 16'hFFFE, 16'hFFFF, 16'h0000};

        // Reset state and plain streaming.
        rst = 1'b1;
        step();
        do_reset();
        mark();
        step();
        check("reset_valid", 32'(s_valid), 32'd0);
        check("reset_addr", 32'(s_addr), 32'h0000);
        check("reset_req", 32'(s_req), 32'd1);
        for (int i = 0; i < 20; i++) step();
        check("first_latency", 32'(fv_cyc - fg_cyc), 32'(LAT_MIN));
        check("stream_pc0", 32'(cap[0]), 32'h0000);
        check("stream_pc1", 32'(cap[1]), 32'h0001);

        // Held stall fills exactly DEPTH credits, then drains back-to-back.
        do_reset();
        stall    = 1'b1;
        n_grants = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) check("stall_hold_ir", 32'(s_ir), 32'h1000);
        end
        check("stall_grants", 32'(n_grants), 32'd4);
        check("stall_req_off", 32'(s_req), 32'd0);
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_head_pc", 32'(s_pc), 32'h0000);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_consecutive", 32'(s_valid), 32'd1);
        end
        for (int i = 0; i < 6; i++) step();

        // Redirect scenarios.
        foreach (vecs[k]) begin
            int w;
            do_reset();
            lat = vecs[k].lat;
            w   = 0;
            while (w < 50 && !(pend.size() == vecs[k].need_pend &&
                               (!vecs[k].need_rv || pend[0].due <= cyc))) begin
                step();
                w++;
            end
            check("redir_setup_timeout", 32'(w < 50), 32'd1);
            redir    = 1'b1;
            redir_pc = vecs[k].rpc;
            gnt_en   = vecs[k].gnt_in_redir;
            step();
            redir  = 1'b0;
            gnt_en = 1'b1;
            mark();
            step();
            check("redir_next_valid", 32'(s_valid), 32'd0);
            check("redir_next_addr", 32'(s_addr), 32'(vecs[k].rpc));
            for (int i = 0; i < 14; i++) step();
            check("redir_pc0", 32'(cap[0]), 32'(vecs[k].exp0));
            check("redir_pc1", 32'(cap[1]), 32'(vecs[k].exp1));
            check("redir_pc2", 32'(cap[2]), 32'(vecs[k].exp2));
        end

        // Reset with three words buffered, then restart latency.
        do_reset();
        lat   = 1;
        stall = 1'b1;
        for (int i = 0; i < 20 && (expq.size() - pend.size()) != 3; i++) step();
        check("buffered_three", 32'(expq.size() - pend.size()), 32'd3);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        mark();
        step();
        check("midreset_valid", 32'(s_valid), 32'd0);
        check("midreset_addr", 32'(s_addr), 32'h0000);
        for (int i = 0; i < 6; i++) step();
        check("restart_latency", 32'(fv_cyc - fg_cyc), 32'(LAT_MIN));
        check("restart_pc0", 32'(cap[0]), 32'h0000);

        // Stop granting and let every delivered word be consumed.
        gnt_en = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("drain_empty", 32'(expq.size()), 32'd0);
        check("drain_idle_valid", 32'(s_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
